// File: rtl/zscroll_plot_engine_if.sv
// SDRAM glue bundle for the scrolling plot engine: one 4-word-burst read
// channel and one 4-word-burst write channel, each a held request answered
// by a single-cycle done strobe.
interface zscroll_plot_engine_if;
  logic        oSDRAM_Rd_Req;
  logic [23:0] oSDRAM_Rd_Addr;
  logic [15:0] iSDRAM_Data1;
  logic [15:0] iSDRAM_Data2;
  logic [15:0] iSDRAM_Data3;
  logic [15:0] iSDRAM_Data4;
  logic        iSDRAM_Rd_Done;
  logic        oSDRAM_Wr_Req;
  logic [23:0] oSDRAM_Wr_Addr;
  logic [15:0] oSDRAM_Wr_Data1;
  logic [15:0] oSDRAM_Wr_Data2;
  logic [15:0] oSDRAM_Wr_Data3;
  logic [15:0] oSDRAM_Wr_Data4;
  logic        iSDRAM_Wr_Done;

  // Engine side.
  modport master (
    output oSDRAM_Rd_Req, oSDRAM_Rd_Addr,
    input  iSDRAM_Data1, iSDRAM_Data2, iSDRAM_Data3, iSDRAM_Data4, iSDRAM_Rd_Done,
    output oSDRAM_Wr_Req, oSDRAM_Wr_Addr,
    output oSDRAM_Wr_Data1, oSDRAM_Wr_Data2, oSDRAM_Wr_Data3, oSDRAM_Wr_Data4,
    input  iSDRAM_Wr_Done
  );

  // SDRAM glue side.
  modport slave (
    input  oSDRAM_Rd_Req, oSDRAM_Rd_Addr,
    output iSDRAM_Data1, iSDRAM_Data2, iSDRAM_Data3, iSDRAM_Data4, iSDRAM_Rd_Done,
    input  oSDRAM_Wr_Req, oSDRAM_Wr_Addr,
    input  oSDRAM_Wr_Data1, oSDRAM_Wr_Data2, oSDRAM_Wr_Data3, oSDRAM_Wr_Data4,
    output iSDRAM_Wr_Done
  );
endinterface

// File: rtl/zscroll_plot_engine.sv
// Scrolling bar-plot renderer. Keeps the last POINTS samples in an SDRAM ring
// (one 4-word slot per sample) and, for every new sample, appends it and
// redraws all columns oldest-first into the LCD framebuffer.
// Optional feature: define ZSCROLL_PEAK_MARK_EN to paint the topmost bar burst
// of every non-empty column in PEAK_COLOR (write count is unchanged).
module zscroll_plot_engine #(
  parameter int unsigned   POINTS      = 600,
  parameter int unsigned   BURST       = 4,
  parameter int unsigned   STRIDE      = 480,
  parameter int unsigned   ORG_X       = 15,
  parameter int unsigned   ORG_Y       = 20,
  parameter int unsigned   PLOT_H      = 220,
  parameter int unsigned   RING_BASE   = 384000,
  parameter int unsigned   SCALE_SHIFT = 0,
  parameter logic [15:0]   FG_COLOR    = 16'hF81F,
  parameter logic [15:0]   BG_COLOR    = 16'h8410
`ifdef ZSCROLL_PEAK_MARK_EN
  , parameter logic [15:0] PEAK_COLOR  = 16'hFFE0
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         iDataUpdate,
  input  logic [15:0]                  iSample,
  zscroll_plot_engine_if.master        sdram,
  output logic                         oBusy,
  output logic                         oFrameDone,
  output logic                         oOverrun
);

  localparam int unsigned     IDX_W    = 10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POINTS - 1);
  localparam logic [15:0]     H_FULL   = 16'(PLOT_H);
  localparam logic [15:0]     LAST_X   = 16'(PLOT_H - BURST);
  localparam logic [15:0]     BURST_W  = 16'(BURST);

  typedef enum logic [2:0] {
    ST_CLR_RING, ST_CLR_PLOT, ST_WAIT, ST_WR_NEW,
    ST_RD_COL, ST_DRAW_FG, ST_DRAW_BG, ST_NEXT_COL
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  head_q, head_d;     // slot that receives the next sample
  logic [IDX_W-1:0]  idx_q, idx_d;       // ring-clear slot counter
  logic [IDX_W-1:0]  col_q, col_d;       // plot column being drawn
  logic [IDX_W-1:0]  slot_q, slot_d;     // ring slot feeding the current column
  logic [15:0]       x_q, x_d;           // bar-axis offset of the next burst
  logic [15:0]       h_q, h_d;           // rounded bar height of current column
  logic              pending_q, pending_d;
  logic [15:0]       sample_q, sample_d; // latest captured, not yet consumed
  logic [15:0]       cur_q, cur_d;       // sample being appended this redraw
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic [23:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;

  logic              idle;
  logic              xact_done;
  logic              consume;
  logic [15:0]       rd_h;
  logic [15:0]       fg_word;
  logic [IDX_W-1:0]  head_next;
  logic [IDX_W-1:0]  slot_next;

  function automatic logic [23:0] ring_addr(input logic [IDX_W-1:0] k);
    return 24'(RING_BASE + BURST * 32'(k));
  endfunction

  function automatic logic [23:0] pix_addr(input logic [IDX_W-1:0] c, input logic [15:0] x);
    return 24'((ORG_Y + 32'(c)) * STRIDE + ORG_X + 32'(x));
  endfunction

  // Clamp to full scale first, then round up to whole bursts; the clamp keeps
  // the rounded value within PLOT_H because PLOT_H is a burst multiple.
  function automatic logic [15:0] bar_height(input logic [15:0] s);
    logic [15:0] v;
    logic [15:0] c;
    v = s >> SCALE_SHIFT;
    c = (v > H_FULL) ? H_FULL : v;
    return (c + (BURST_W - 16'd1)) & ~(BURST_W - 16'd1);
  endfunction

  // Next-state, transaction sequencing and sample capture.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    head_d       = head_q;
    idx_d        = idx_q;
    col_d        = col_q;
    slot_d       = slot_q;
    x_d          = x_q;
    h_d          = h_q;
    pending_d    = pending_q;
    sample_d     = sample_q;
    cur_d        = cur_q;
    rd_req_d     = rd_req_q;
    wr_req_d     = wr_req_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    consume      = 1'b0;

    idle      = !rd_req_q && !wr_req_q;
    // A done strobe only counts while its own request is up.
    xact_done = (rd_req_q && sdram.iSDRAM_Rd_Done) || (wr_req_q && sdram.iSDRAM_Wr_Done);
    rd_h      = bar_height(sdram.iSDRAM_Data1);
    head_next = (head_q == LAST_IDX) ? '0 : head_q + 10'd1;
    slot_next = (slot_q == LAST_IDX) ? '0 : slot_q + 10'd1;
`ifdef ZSCROLL_PEAK_MARK_EN
    fg_word   = (x_q == h_q - BURST_W) ? PEAK_COLOR : FG_COLOR;
`else
    fg_word   = FG_COLOR;
`endif

    // Each bus state issues its request in the first idle cycle, then waits
    // for done; the request drops on the edge that samples done.
    case (state_q)
      ST_CLR_RING: begin
        if (idle) begin
          wr_req_d = 1'b1;
          addr_d   = ring_addr(idx_q);
          wdata_d  = '0;
        end else if (xact_done) begin
          wr_req_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            col_d   = '0;
            x_d     = '0;
            state_d = ST_CLR_PLOT;
          end else begin
            idx_d = idx_q + 10'd1;
          end
        end
      end

      ST_CLR_PLOT: begin
        if (idle) begin
          wr_req_d = 1'b1;
          addr_d   = pix_addr(col_q, x_q);
          wdata_d  = BG_COLOR;
        end else if (xact_done) begin
          wr_req_d = 1'b0;
          if (x_q == LAST_X) begin
            x_d = '0;
            if (col_q == LAST_IDX) state_d = ST_WAIT;
            else                   col_d   = col_q + 10'd1;
          end else begin
            x_d = x_q + BURST_W;
          end
        end
      end

      ST_WAIT: begin
        if (pending_q && en) begin
          consume = 1'b1;
          cur_d   = sample_q;
          state_d = ST_WR_NEW;
        end
      end

      ST_WR_NEW: begin
        if (idle) begin
          wr_req_d = 1'b1;
          addr_d   = ring_addr(head_q);
          wdata_d  = cur_q;
        end else if (xact_done) begin
          wr_req_d = 1'b0;
          head_d   = head_next;
          slot_d   = head_next;   // slot after the newest is the oldest
          col_d    = '0;
          state_d  = ST_RD_COL;
        end
      end

      ST_RD_COL: begin
        if (idle) begin
          rd_req_d = 1'b1;
          addr_d   = ring_addr(slot_q);
        end else if (xact_done) begin
          rd_req_d = 1'b0;
          h_d      = rd_h;
          x_d      = '0;
          state_d  = (rd_h == 16'd0) ? ST_DRAW_BG : ST_DRAW_FG;
        end
      end

      ST_DRAW_FG: begin
        if (idle) begin
          wr_req_d = 1'b1;
          addr_d   = pix_addr(col_q, x_q);
          wdata_d  = fg_word;
        end else if (xact_done) begin
          wr_req_d = 1'b0;
          if (x_q == h_q - BURST_W) begin
            x_d = h_q;
            if (h_q == H_FULL) begin
              frame_done_d = (col_q == LAST_IDX);
              state_d      = ST_NEXT_COL;
            end else begin
              state_d = ST_DRAW_BG;
            end
          end else begin
            x_d = x_q + BURST_W;
          end
        end
      end

      ST_DRAW_BG: begin
        if (idle) begin
          wr_req_d = 1'b1;
          addr_d   = pix_addr(col_q, x_q);
          wdata_d  = BG_COLOR;
        end else if (xact_done) begin
          wr_req_d = 1'b0;
          if (x_q == LAST_X) begin
            frame_done_d = (col_q == LAST_IDX);
            state_d      = ST_NEXT_COL;
          end else begin
            x_d = x_q + BURST_W;
          end
        end
      end

      ST_NEXT_COL: begin
        if (col_q == LAST_IDX) begin
          state_d = ST_WAIT;
        end else begin
          col_d   = col_q + 10'd1;
          slot_d  = slot_next;
          state_d = ST_RD_COL;
        end
      end

      default: state_d = ST_CLR_RING;
    endcase

    // A strobe in the same cycle the old sample is consumed is not an overrun.
    if (consume) pending_d = 1'b0;
    if (iDataUpdate) begin
      if (pending_q && !consume) overrun_d = 1'b1;
      pending_d = 1'b1;
      sample_d  = iSample;
    end

    busy_d = (state_d != ST_WAIT);
  end

  // State and datapath registers; reset drops any request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CLR_RING;
      head_q       <= '0;
      idx_q        <= '0;
      col_q        <= '0;
      slot_q       <= '0;
      x_q          <= '0;
      h_q          <= '0;
      pending_q    <= 1'b0;
      sample_q     <= '0;
      cur_q        <= '0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q      <= state_d;
      head_q       <= head_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      slot_q       <= slot_d;
      x_q          <= x_d;
      h_q          <= h_d;
      pending_q    <= pending_d;
      sample_q     <= sample_d;
      cur_q        <= cur_d;
      rd_req_q     <= rd_req_d;
      wr_req_q     <= wr_req_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sdram.oSDRAM_Rd_Req   = rd_req_q;
  assign sdram.oSDRAM_Rd_Addr  = addr_q;
  assign sdram.oSDRAM_Wr_Req   = wr_req_q;
  assign sdram.oSDRAM_Wr_Addr  = addr_q;
  assign sdram.oSDRAM_Wr_Data1 = wdata_q;
  assign sdram.oSDRAM_Wr_Data2 = wdata_q;
  assign sdram.oSDRAM_Wr_Data3 = wdata_q;
  assign sdram.oSDRAM_Wr_Data4 = wdata_q;
  assign oBusy      = busy_q;
  assign oFrameDone = frame_done_q;
  assign oOverrun   = overrun_q;

endmodule

// File: tb/tb_zscroll_plot_engine.sv
// Directed bench for zscroll_plot_engine with a small plot (8 columns, 16 px)
// and a behavioural SDRAM that answers each request after 1-8 cycles.
module tb_zscroll_plot_engine;

  localparam int P  = 8;
  localparam int H  = 16;
  localparam int S  = 32;
  localparam int OX = 15;
  localparam int OY = 20;
  localparam int RB = 384000;
  localparam logic [15:0] FG = 16'hF81F;
  localparam logic [15:0] BG = 16'h8410;
  localparam logic [15:0] PK = 16'hFFE0;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        upd;
  logic [15:0] smp;
  logic        busy;
  logic        fdone;
  logic        ovr;

  zscroll_plot_engine_if sd ();

  zscroll_plot_engine #(.POINTS(P), .PLOT_H(H), .STRIDE(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .iDataUpdate (upd),
    .iSample     (smp),
    .sdram       (sd),
    .oBusy       (busy),
    .oFrameDone  (fdone),
    .oOverrun    (ovr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // SDRAM contents and bus statistics.
  logic [15:0] mem [int];
  int ring_wr, fb_wr, fg_cnt, bg_cnt, pk_cnt, rd_cnt, max_x;
  int fg_col [P];
  int bg_col [P];
  int data_err = 0, proto_err = 0, stab_err = 0;
  int frame_cnt, ovr_cnt;
  int exp_h [P];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    ring_wr = 0; fb_wr = 0; fg_cnt = 0; bg_cnt = 0; pk_cnt = 0;
    rd_cnt = 0; max_x = 0; frame_cnt = 0; ovr_cnt = 0;
    for (int c = 0; c < P; c++) begin
      fg_col[c] = 0;
      bg_col[c] = 0;
    end
  endtask

  // Behavioural SDRAM: latches a request, answers after a random latency.
  initial begin
    int lat;
    bit act;
    int a;
    int c;
    int x;
    act = 1'b0;
    lat = 0;
    sd.iSDRAM_Rd_Done = 1'b0;
    sd.iSDRAM_Wr_Done = 1'b0;
    sd.iSDRAM_Data1 = '0;
    sd.iSDRAM_Data2 = '0;
    sd.iSDRAM_Data3 = '0;
    sd.iSDRAM_Data4 = '0;
    forever begin
      @(posedge clk);
      #1;
      sd.iSDRAM_Rd_Done = 1'b0;
      sd.iSDRAM_Wr_Done = 1'b0;
      if (rst === 1'b1) begin
        act = 1'b0;
      end else if (act) begin
        lat--;
        if (lat == 0) begin
          act = 1'b0;
          if (sd.oSDRAM_Wr_Req) begin
            a = int'(sd.oSDRAM_Wr_Addr);
            if (sd.oSDRAM_Wr_Data2 !== sd.oSDRAM_Wr_Data1 || sd.oSDRAM_Wr_Data3 !== sd.oSDRAM_Wr_Data1 ||
                sd.oSDRAM_Wr_Data4 !== sd.oSDRAM_Wr_Data1) data_err++;
            mem[a] = sd.oSDRAM_Wr_Data1;
            if (a >= RB) begin
              ring_wr++;
            end else begin
              fb_wr++;
              c = a / S - OY;
              x = a % S - OX;
              if (c < 0 || c >= P || x < 0 || x > H - 4) begin
                data_err++;
              end else begin
                if (x > max_x) max_x = x;
                if (sd.oSDRAM_Wr_Data1 == FG) begin fg_cnt++; fg_col[c]++; end
                else if (sd.oSDRAM_Wr_Data1 == PK) begin pk_cnt++; fg_col[c]++; end
                else if (sd.oSDRAM_Wr_Data1 == BG) begin bg_cnt++; bg_col[c]++; end
                else data_err++;
              end
            end
            sd.iSDRAM_Wr_Done = 1'b1;
          end else if (sd.oSDRAM_Rd_Req) begin
            a = int'(sd.oSDRAM_Rd_Addr);
            rd_cnt++;
            sd.iSDRAM_Data1 = mem[a];
            sd.iSDRAM_Data2 = mem[a];
            sd.iSDRAM_Data3 = mem[a];
            sd.iSDRAM_Data4 = mem[a];
            sd.iSDRAM_Rd_Done = 1'b1;
          end else begin
            data_err++;
          end
        end
      end else if (sd.oSDRAM_Wr_Req || sd.oSDRAM_Rd_Req) begin
        act = 1'b1;
        lat = int'($urandom_range(1, 8));
      end
    end
  end

  // Bus-rule and pulse monitor, sampled mid-cycle.
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  logic [23:0] prev_ra, prev_wa;
  logic [15:0] prev_wd;
  always @(negedge clk) begin
    if (sd.oSDRAM_Rd_Req && sd.oSDRAM_Wr_Req) proto_err++;
    if (prev_wr && sd.oSDRAM_Wr_Req && (sd.oSDRAM_Wr_Addr != prev_wa || sd.oSDRAM_Wr_Data1 != prev_wd)) stab_err++;
    if (prev_rd && sd.oSDRAM_Rd_Req && sd.oSDRAM_Rd_Addr != prev_ra) stab_err++;
    prev_rd = sd.oSDRAM_Rd_Req;
    prev_wr = sd.oSDRAM_Wr_Req;
    prev_ra = sd.oSDRAM_Rd_Addr;
    prev_wa = sd.oSDRAM_Wr_Addr;
    prev_wd = sd.oSDRAM_Wr_Data1;
    if (fdone === 1'b1) frame_cnt++;
    if (ovr === 1'b1) ovr_cnt++;
  end

  task automatic strobe(input logic [15:0] v);
    @(negedge clk);
    smp = v;
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, busy, 1'b0);
  endtask

  task automatic wait_frame(input string tag, input int count);
    int n;
    int start;
    n = 0;
    start = frame_cnt;
    while (frame_cnt < start + count && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " frame reached"}, (frame_cnt >= start + count), 1'b1);
    wait_idle(tag);
  endtask

  // Compares every framebuffer burst against the bar heights in exp_h.
  task automatic check_frame(input string tag);
    logic [15:0] e;
    for (int c = 0; c < P; c++) begin
      for (int x = 0; x < H; x += 4) begin
        e = (x < exp_h[c]) ? FG : BG;
`ifdef ZSCROLL_PEAK_MARK_EN
        if (exp_h[c] > 0 && x == exp_h[c] - 4) e = PK;
`endif
        check($sformatf("%s pix c%0d x%0d", tag, c, x), mem[(OY + c) * S + OX + x], e);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    en  = 1'b0;
    upd = 1'b0;
    smp = '0;
    for (int k = 0; k < P; k++) mem[RB + 4 * k] = 16'hDEAD;
    for (int c = 0; c < P; c++)
      for (int x = 0; x < H; x++) mem[(OY + c) * S + OX + x] = 16'h1234;
    clear_counts();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // 1: reset state, then ring clear and background clear.
    check("rst rd_req", sd.oSDRAM_Rd_Req, 1'b0);
    check("rst wr_req", sd.oSDRAM_Wr_Req, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst frame_done", fdone, 1'b0);
    check("rst overrun", ovr, 1'b0);
    rst = 1'b0;
    wait_idle("init");
    check("init ring writes", ring_wr, 8);
    check("init fb writes", fb_wr, 32);
    check("init fg writes", fg_cnt + pk_cnt, 0);
    check("init reads", rd_cnt, 0);
    check("init no frame pulse", frame_cnt, 0);
    for (int k = 0; k < P; k++) check($sformatf("init slot%0d", k), mem[RB + 4 * k], 16'h0);
    exp_h = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_frame("init");

    // 2: single sample 9 lands in slot 0 and is drawn as the newest column.
    en = 1'b1;
    clear_counts();
    strobe(16'd9);
    wait_frame("s9", 1);
    check("s9 slot0", mem[RB], 16'd9);
    check("s9 frame pulses", frame_cnt, 1);
    check("s9 ring writes", ring_wr, 1);
    check("s9 fb writes", fb_wr, 32);
    check("s9 reads", rd_cnt, 8);
    check("s9 col7 fg", fg_col[7], 3);
    check("s9 col7 bg", bg_col[7], 1);
    exp_h = '{0, 0, 0, 0, 0, 0, 0, 12};
    check_frame("s9");

    // 3: fresh init, then samples 1..9 wrap the ring once.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_idle("reinit");
    for (int v = 1; v <= 9; v++) begin
      if (v == 9) clear_counts();
      strobe(16'(v));
      wait_frame($sformatf("seq%0d", v), 1);
    end
    check("seq slot0 wrapped", mem[RB], 16'd9);
    check("seq slot1", mem[RB + 4], 16'd2);
    check("seq fg writes", fg_cnt + pk_cnt, 14);
    check("seq bg writes", bg_cnt, 18);
    exp_h = '{4, 4, 4, 8, 8, 8, 8, 12};
    check_frame("seq");

    // 4: oversized sample clamps to full scale.
    clear_counts();
    strobe(16'd500);
    wait_frame("big", 1);
    check("big slot1", mem[RB + 4], 16'd500);
    check("big col7 fg", fg_col[7], 4);
    check("big col7 bg", bg_col[7], 0);
    check("big max x", max_x, 12);
    exp_h = '{4, 4, 8, 8, 8, 8, 12, 16};
    check_frame("big");

    // 4b: en low holds the sample pending without starting a redraw.
    en = 1'b0;
    clear_counts();
    strobe(16'd7);
    repeat (60) @(negedge clk);
    check("en0 busy", busy, 1'b0);
    check("en0 writes", ring_wr + fb_wr, 0);
    en = 1'b1;
    wait_frame("en1", 1);
    check("en1 slot2", mem[RB + 8], 16'd7);
    check("en1 frame pulses", frame_cnt, 1);

    // 5: three strobes; the middle one is overwritten while pending.
    clear_counts();
    strobe(16'd13);
    repeat (20) @(negedge clk);
    check("ovr busy in redraw", busy, 1'b1);
    strobe(16'd2);
    repeat (20) @(negedge clk);
    strobe(16'd10);
    wait_frame("ovr", 2);
    check("ovr pulses", ovr_cnt, 1);
    check("ovr frames", frame_cnt, 2);
    check("ovr slot3", mem[RB + 12], 16'd13);
    check("ovr slot4", mem[RB + 16], 16'd10);
    exp_h = '{8, 8, 8, 12, 16, 8, 16, 12};
    check_frame("ovr");

    // 6: reset in the middle of a bar write, then re-init.
    clear_counts();
    strobe(16'd16);
    n = 0;
    while (!(sd.oSDRAM_Wr_Req === 1'b1 && sd.oSDRAM_Wr_Data1 === FG) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("midfg found", (n < 3000), 1'b1);
    rst = 1'b1;
    #1;
    check("midfg rd_req async", sd.oSDRAM_Rd_Req, 1'b0);
    check("midfg wr_req async", sd.oSDRAM_Wr_Req, 1'b0);
    @(posedge clk);
    #1;
    check("midfg rd_req edge", sd.oSDRAM_Rd_Req, 1'b0);
    check("midfg wr_req edge", sd.oSDRAM_Wr_Req, 1'b0);
    check("midfg busy", busy, 1'b0);
    @(negedge clk);
    clear_counts();
    rst = 1'b0;
    wait_idle("midfg init");
    check("midfg ring writes", ring_wr, 8);
    check("midfg fb writes", fb_wr, 32);
    for (int k = 0; k < P; k++) check($sformatf("midfg slot%0d", k), mem[RB + 4 * k], 16'h0);
    exp_h = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_frame("midfg");

    // Top-burst colour with and without the peak marker.
    clear_counts();
    strobe(16'd9);
    wait_frame("peak", 1);
    check("peak col7 bursts", fg_col[7], 3);
`ifdef ZSCROLL_PEAK_MARK_EN
    check("peak marks", pk_cnt, 1);
    check("peak fg", fg_cnt, 2);
`else
    check("peak marks", pk_cnt, 0);
    check("peak fg", fg_cnt, 3);
`endif
    exp_h = '{0, 0, 0, 0, 0, 0, 0, 12};
    check_frame("peak");

    check("bus rd/wr overlap", proto_err, 0);
    check("bus stability", stab_err, 0);
    check("bus data/address", data_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
